regfile_mp: RTL and testbench

- Parametrised successor to the 2-read/1-write MIPS general-purpose register file.
- Configurable data width, depth and read-port count; two write ports with fixed priority; write-to-read bypass on every read port.
- Built-in post-reset clear sequencer, so every entry reads zero after init, without a reset fan-out to the whole array.
- Sits between the ID stage (read ports) and the WB stage (write ports; port 1 is the second retire lane / HI-LO move path).

---
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp.sv | 78 +++++++
 tb/tb_regfile_mp.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file access bundle: two WB-side write lanes, NUM_RD ID-side read lanes,
// plus the ready and write-conflict status flags.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       we0;
    logic [ADDR_W-1:0]          waddr0;
    logic [DATA_W-1:0]          wdata0;
    logic                       we1;
    logic [ADDR_W-1:0]          waddr1;
    logic [DATA_W-1:0]          wdata1;
    logic [NUM_RD-1:0]          re;
    logic [NUM_RD*ADDR_W-1:0]   raddr;
    logic [NUM_RD*DATA_W-1:0]   rdata;
    logic                       ready;
    logic                       wconf;

    modport master (
        output we0, waddr0, wdata0,
        output we1, waddr1, wdata1,
        output re, raddr,
        input  rdata, ready, wconf
    );

    modport slave (
        input  we0, waddr0, wdata0,
        input  we1, waddr1, wdata1,
        input  re, raddr,
        output rdata, ready, wconf
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: r0 hardwired zero, two prioritised write ports, per-lane
// write-to-read bypass, and a post-reset sweep that clears r1..rN without resetting the array.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input logic        clk,
    input logic        rst,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [ADDR_W-1:0] init_ptr;
    logic              ready;
    logic              active;
    logic              wr0;
    logic              wr1;
    logic              same_addr;

    assign active    = ready & ~rst;
    assign same_addr = (bus.waddr0 == bus.waddr1);
    assign wr1       = active & bus.we1 & (bus.waddr1 != '0);
    // Port 1 wins a same-address collision; port 0 data is dropped.
    assign wr0       = active & bus.we0 & (bus.waddr0 != '0) & ~(wr1 & same_addr);

    assign bus.wconf = active & bus.we0 & bus.we1 & same_addr & (bus.waddr0 != '0);
    assign bus.ready = ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready    <= 1'b0;
            init_ptr <= ADDR_W'(1);
        end else if (!ready) begin
            if (init_ptr == LAST) begin
                ready <= 1'b1;
            end else begin
                init_ptr <= init_ptr + 1'b1;
            end
        end
    end

    // The array has no reset; the clear sweep walks one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!ready) begin
                regs[init_ptr] <= '0;
            end else begin
                if (wr0) regs[bus.waddr0] <= bus.wdata0;
                if (wr1) regs[bus.waddr1] <= bus.wdata1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] lane;

        assign addr = bus.raddr[i*ADDR_W +: ADDR_W];

        always_comb begin
            lane = '0;
            if (!active || !bus.re[i] || addr == '0) begin
                lane = '0;
            end else if (bus.we1 && bus.waddr1 == addr) begin
                lane = bus.wdata1;
            end else if (bus.we0 && bus.waddr0 == addr) begin
                lane = bus.wdata0;
            end else begin
                lane = regs[addr];
            end
        end

        assign bus.rdata[i*DATA_W +: DATA_W] = lane;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: expectations are queued as stimulus is applied and
// compared once the combinational outputs have settled, away from the clock edge.
module tb_regfile_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int SEL_READY = 8;
    localparam int SEL_WCONF = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int sel);
        if (sel == SEL_READY) return {31'b0, bus.ready};
        if (sel == SEL_WCONF) return {31'b0, bus.wconf};
        return bus.rdata[sel*DW +: DW];
    endfunction

    task automatic expect_out(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
    endtask

    task automatic set_idle();
        bus.we0    = 1'b0;
        bus.waddr0 = '0;
        bus.wdata0 = '0;
        bus.we1    = 1'b0;
        bus.waddr1 = '0;
        bus.wdata1 = '0;
        bus.re     = '0;
        bus.raddr  = '0;
    endtask

    task automatic set_rd(input int lane, input logic [AW-1:0] addr);
        bus.raddr[lane*AW +: AW] = addr;
        bus.re[lane]             = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Walk n edges after reset release, checking ready each edge; optionally poke
    // writes and reads mid-sequence to show they are ignored.
    task automatic init_check(input int n, input bit poke);
        for (int e = 1; e <= n; e++) begin
            tick();
            expect_out("ready_init", SEL_READY, (e == 31) ? 32'd1 : 32'd0);
            if (poke && e == 4) begin
                bus.we1 = 1'b1; bus.waddr1 = 5'd4; bus.wdata1 = 32'h0000_0BAD;
                bus.we0 = 1'b1; bus.waddr0 = 5'd4; bus.wdata0 = 32'h0000_BAD0;
                expect_out("wconf_init", SEL_WCONF, 32'd0);
            end
            if (poke && e == 10) begin
                set_rd(0, 5'd4);
                set_rd(1, 5'd17);
                expect_out("rd_init_l0", 0, 32'd0);
                expect_out("rd_init_l1", 1, 32'd0);
            end
            drain();
            if (poke && (e == 5 || e == 10)) set_idle();
        end
    endtask

    initial begin
        set_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        set_rd(0, 5'd3);
        expect_out("rst_ready", SEL_READY, 32'd0);
        expect_out("rst_wconf", SEL_WCONF, 32'd0);
        expect_out("rst_rdata", 0, 32'd0);
        drain();
        set_idle();
        rst = 1'b0;
        init_check(31, 1'b0);

        // Fill every entry with non-zero data so the next clear sweep is observable.
        for (int i = 1; i < 32; i++) begin
            bus.we0    = 1'b1;
            bus.waddr0 = AW'(i);
            bus.wdata0 = 32'hA500_0000 | i;
            tick();
        end
        set_idle();
        set_rd(0, 5'd17);
        set_rd(1, 5'd31);
        expect_out("preload_r17", 0, 32'hA500_0011);
        expect_out("preload_r31", 1, 32'hA500_001F);
        drain();
        set_idle();

        // Clear sequence with writes attempted during init
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        init_check(31, 1'b1);
        for (int i = 1; i < 32; i++) begin
            set_rd(0, AW'(i));
            set_rd(1, AW'(32 - i));
            expect_out("clear_l0", 0, 32'd0);
            expect_out("clear_l1", 1, 32'd0);
            drain();
            tick();
        end
        set_idle();

        // Basic write then read
        bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEAD_BEEF;
        tick();
        set_idle();
        set_rd(0, 5'd5);
        set_rd(1, 5'd0);
        expect_out("basic_l0", 0, 32'hDEAD_BEEF);
        expect_out("basic_l1", 1, 32'd0);
        drain();
        set_idle();

        // Same-cycle bypass, then masked by re
        bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h0000_0011;
        set_rd(1, 5'd7);
        expect_out("bypass_l1", 1, 32'h0000_0011);
        expect_out("bypass_l0_off", 0, 32'd0);
        drain();
        bus.re[1] = 1'b0;
        expect_out("bypass_re_off", 1, 32'd0);
        drain();
        tick();
        set_idle();
        set_rd(1, 5'd7);
        expect_out("bypass_stored", 1, 32'h0000_0011);
        drain();
        set_idle();

        // Dual-write conflict
        bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h0000_AAAA;
        bus.we1 = 1'b1; bus.waddr1 = 5'd9; bus.wdata1 = 32'h0000_5555;
        set_rd(0, 5'd9);
        expect_out("conf_wconf", SEL_WCONF, 32'd1);
        expect_out("conf_bypass", 0, 32'h0000_5555);
        drain();
        tick();
        set_idle();
        set_rd(0, 5'd9);
        expect_out("conf_stored", 0, 32'h0000_5555);
        expect_out("conf_wconf_clr", SEL_WCONF, 32'd0);
        drain();
        set_idle();

        // Writes to r0
        bus.we1 = 1'b1; bus.waddr1 = 5'd0; bus.wdata1 = 32'hFFFF_FFFF;
        bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'h0000_1234;
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        expect_out("r0_l0", 0, 32'd0);
        expect_out("r0_l1", 1, 32'd0);
        expect_out("r0_wconf", SEL_WCONF, 32'd0);
        drain();
        tick();
        set_idle();
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        expect_out("r0_after_l0", 0, 32'd0);
        expect_out("r0_after_l1", 1, 32'd0);
        drain();
        set_idle();

        // Two ports, distinct addresses
        bus.we0 = 1'b1; bus.waddr0 = 5'd10; bus.wdata0 = 32'h0000_0A0A;
        bus.we1 = 1'b1; bus.waddr1 = 5'd11; bus.wdata1 = 32'h0000_0B0B;
        set_rd(0, 5'd10);
        set_rd(1, 5'd11);
        expect_out("dual_wconf", SEL_WCONF, 32'd0);
        expect_out("dual_byp_l0", 0, 32'h0000_0A0A);
        expect_out("dual_byp_l1", 1, 32'h0000_0B0B);
        drain();
        tick();
        set_idle();
        set_rd(0, 5'd10);
        set_rd(1, 5'd11);
        expect_out("dual_st_l0", 0, 32'h0000_0A0A);
        expect_out("dual_st_l1", 1, 32'h0000_0B0B);
        drain();
        set_idle();

        // Reset restarted mid-init
        bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h0000_0033;
        tick();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        init_check(10, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        init_check(31, 1'b0);
        set_rd(0, 5'd3);
        expect_out("midinit_r3", 0, 32'd0);
        drain();
        set_idle();

        // Reset mid-run
        bus.we0 = 1'b1; bus.waddr0 = 5'd3; bus.wdata0 = 32'h0000_0033;
        tick();
        set_idle();
        set_rd(0, 5'd3);
        expect_out("midrun_r3_set", 0, 32'h0000_0033);
        drain();
        set_idle();
        rst = 1'b1;
        tick();
        expect_out("midrun_rst_ready", SEL_READY, 32'd0);
        drain();
        rst = 1'b0;
        init_check(31, 1'b0);
        set_rd(0, 5'd3);
        expect_out("midrun_r3_clr", 0, 32'd0);
        drain();
        set_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
